// File: rtl/id_exe_ctrl_reg_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU/branch opcode enums and the decoded control bundle.
// The EXE ALU imports this package so both sides agree on the encodings.
package id_exe_ctrl_reg_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3,
    BR_BGE  = 3'd4, BR_BLTU = 3'd5, BR_BGEU = 3'd6
  } br_op_e;

  typedef struct packed {
    alu_op_e                 alu;
    br_op_e                  br;
    logic [DATA_WIDTH-1:0]   imm;
    logic                    src_imm;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    jal;
    logic                    jalr;
    logic                    illegal;
  } dec_t;

  // funct7[5] selects sub only for register-register ops; it selects sra for both.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
    return DATA_WIDTH'($signed(v));
  endfunction

endpackage

// File: rtl/id_exe_ctrl_reg_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle plus source-register usage.
module id_decoder
  import id_exe_ctrl_reg_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opc    = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  always_comb begin
    dec_o      = '0;
    dec_o.rs1  = instr_i[19:15];
    dec_o.rs2  = instr_i[24:20];
    dec_o.rd   = instr_i[11:7];
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opc)
      OP_R: begin
        dec_o.alu       = alu_from_f3(f3, f7[5], 1'b1);
        dec_o.reg_write = 1'b1;
        rs2_used_o      = 1'b1;
      end
      OP_IALU: begin
        dec_o.alu       = alu_from_f3(f3, f7[5], 1'b0);
        dec_o.imm       = sext32(imm_i);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        // Shift-immediates carry only the shamt; funct7 must be a known shift variant.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_o.imm     = sext32(imm_sh);
          dec_o.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
      end
      OP_LOAD: begin
        dec_o.imm       = sext32(imm_i);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.mem_read  = 1'b1;
      end
      OP_STORE: begin
        dec_o.imm       = sext32(imm_s);
        dec_o.src_imm   = 1'b1;
        dec_o.mem_write = 1'b1;
        rs2_used_o      = 1'b1;
      end
      OP_BRANCH: begin
        dec_o.alu  = ALU_SUB;
        dec_o.imm  = sext32(imm_b);
        rs2_used_o = 1'b1;
        case (f3)
          3'b000:  dec_o.br = BR_BEQ;
          3'b001:  dec_o.br = BR_BNE;
          3'b100:  dec_o.br = BR_BLT;
          3'b101:  dec_o.br = BR_BGE;
          3'b110:  dec_o.br = BR_BLTU;
          3'b111:  dec_o.br = BR_BGEU;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec_o.rs1       = 5'd0;
        dec_o.imm       = sext32(imm_u);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        rs1_used_o      = 1'b0;
      end
      OP_AUIPC: begin
        dec_o.imm       = sext32(imm_u);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        rs1_used_o      = 1'b0;
      end
      OP_JAL: begin
        dec_o.imm       = sext32(imm_j);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.jal       = 1'b1;
        rs1_used_o      = 1'b0;
      end
      OP_JALR: begin
        dec_o.imm       = sext32(imm_i);
        dec_o.src_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.jalr      = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    if (dec_o.rd == 5'd0) dec_o.reg_write = 1'b0;
    if (dec_o.illegal) begin
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.jal       = 1'b0;
      dec_o.jalr      = 1'b0;
      dec_o.br        = BR_NONE;
    end
  end

endmodule

// File: rtl/id_exe_ctrl_reg.sv
// ID/EXE pipeline register: decodes the ID instruction and registers it into EXE,
// inserting bubbles for flush, invalid slots and load-use hazards.
module id_exe_ctrl_reg
  import id_exe_ctrl_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  load_use_stall,
  output logic                  exe_valid,
  output logic [DATA_WIDTH-1:0] exe_pc,
  output logic [3:0]            exe_alu_ctrl,
  output logic [2:0]            exe_br_ctrl,
  output logic [DATA_WIDTH-1:0] exe_imm,
  output logic                  exe_alu_src_imm,
  output logic [4:0]            exe_rs1,
  output logic [4:0]            exe_rs2,
  output logic [4:0]            exe_rd,
  output logic                  exe_reg_write,
  output logic                  exe_mem_read,
  output logic                  exe_mem_write,
  output logic                  exe_jal,
  output logic                  exe_jalr,
  output logic                  exe_illegal
);

  dec_t                  dec;
  logic                  rs1_used, rs2_used;
  dec_t                  exe_q, exe_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  id_decoder u_dec (
    .instr_i    (id_instr),
    .dec_o      (dec),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  // A load in EXE whose destination feeds the ID instruction must wait one cycle.
  assign load_use_stall = valid_q & exe_q.mem_read & (exe_q.rd != 5'd0) & id_valid &
                          (((exe_q.rd == dec.rs1) & rs1_used) | ((exe_q.rd == dec.rs2) & rs2_used));

  always_comb begin
    exe_d   = exe_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    if (!hold) begin
      exe_d   = dec;
      pc_d    = id_pc;
      valid_d = id_valid;
      if (flush || load_use_stall || !id_valid) begin
        valid_d         = 1'b0;
        exe_d.reg_write = 1'b0;
        exe_d.mem_read  = 1'b0;
        exe_d.mem_write = 1'b0;
        exe_d.jal       = 1'b0;
        exe_d.jalr      = 1'b0;
        exe_d.illegal   = 1'b0;
        exe_d.br        = BR_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      exe_q   <= exe_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign exe_valid       = valid_q;
  assign exe_pc          = pc_q;
  assign exe_alu_ctrl    = exe_q.alu;
  assign exe_br_ctrl     = exe_q.br;
  assign exe_imm         = exe_q.imm;
  assign exe_alu_src_imm = exe_q.src_imm;
  assign exe_rs1         = exe_q.rs1;
  assign exe_rs2         = exe_q.rs2;
  assign exe_rd          = exe_q.rd;
  assign exe_reg_write   = exe_q.reg_write;
  assign exe_mem_read    = exe_q.mem_read;
  assign exe_mem_write   = exe_q.mem_write;
  assign exe_jal         = exe_q.jal;
  assign exe_jalr        = exe_q.jalr;
  assign exe_illegal     = exe_q.illegal;

endmodule

// File: tb/tb_id_exe_ctrl_reg.sv
// Bench for id_exe_ctrl_reg: directed decode table, hazard/hold/flush/reset sequences,
// and randomized traffic against a rule-level reference model.
module tb_id_exe_ctrl_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        hold, flush;
  logic        load_use_stall, exe_valid;
  logic [31:0] exe_pc, exe_imm;
  logic [3:0]  exe_alu_ctrl;
  logic [2:0]  exe_br_ctrl;
  logic        exe_alu_src_imm;
  logic [4:0]  exe_rs1, exe_rs2, exe_rd;
  logic        exe_reg_write, exe_mem_read, exe_mem_write, exe_jal, exe_jalr, exe_illegal;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  id_exe_ctrl_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .hold(hold), .flush(flush), .load_use_stall(load_use_stall),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_alu_ctrl(exe_alu_ctrl),
    .exe_br_ctrl(exe_br_ctrl), .exe_imm(exe_imm), .exe_alu_src_imm(exe_alu_src_imm),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd),
    .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_jal(exe_jal), .exe_jalr(exe_jalr), .exe_illegal(exe_illegal)
  );

  typedef struct {
    bit         v;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  br;
    bit          src;
    logic [4:0]  rs1, rs2, rd;
    bit          rw, mr, mw, jal, jalr, ill;
  } m_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic [31:0] imm;
    bit          src;
    logic [4:0]  rd, rs1, rs2;
    bit          rw, mr, mw, jal, ill;
  } vec_t;

  m_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode, built directly from the ISA field rules.
  function automatic m_t mdec(input logic [31:0] ins, output bit u1, output bit u2);
    m_t r;
    logic [3:0]  alu_tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [2:0]  br_tab  [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] sx = {32{ins[31]}};
    logic [31:0] ii = (sx << 12) | 32'(ins[31:20]);
    logic [31:0] is = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    logic [31:0] ib = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    logic [31:0] iu = ins & 32'hFFFFF000;
    logic [31:0] ij = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    r = '{default: 0};
    r.v = 1; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7];
    u1 = 1; u2 = 0;
    case (op)
      7'h33: begin
        r.alu = (f3 == 0 && f7[5]) ? 4'd1 : (f3 == 5 && f7[5]) ? 4'd7 : alu_tab[f3];
        r.rw = 1; u2 = 1;
      end
      7'h13: begin
        r.alu = (f3 == 5 && f7[5]) ? 4'd7 : alu_tab[f3];
        r.rw = 1; r.src = 1;
        r.imm = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ii;
        if ((f3 == 1 || f3 == 5) && f7 != 7'h00 && f7 != 7'h20) r.ill = 1;
      end
      7'h03: begin r.mr = 1; r.rw = 1; r.src = 1; r.imm = ii; end
      7'h23: begin r.mw = 1; r.src = 1; r.imm = is; u2 = 1; end
      7'h63: begin
        r.alu = 4'd1; r.imm = ib; u2 = 1;
        r.br = br_tab[f3];
        if (f3 == 2 || f3 == 3) r.ill = 1;
      end
      7'h37: begin r.rw = 1; r.src = 1; r.imm = iu; r.rs1 = 0; u1 = 0; end
      7'h17: begin r.rw = 1; r.src = 1; r.imm = iu; u1 = 0; end
      7'h6F: begin r.rw = 1; r.src = 1; r.imm = ij; r.jal = 1; u1 = 0; end
      7'h67: begin r.rw = 1; r.src = 1; r.imm = ii; r.jalr = 1; end
      default: r.ill = 1;
    endcase
    if (r.rd == 0) r.rw = 0;
    if (r.ill) begin r.rw = 0; r.mr = 0; r.mw = 0; r.jal = 0; r.jalr = 0; r.br = 0; end
    return r;
  endfunction

  task automatic cmp_state(input m_t e);
    chk("exe_valid", 32'(exe_valid), 32'(e.v));
    chk("exe_reg_write", 32'(exe_reg_write), 32'(e.rw));
    chk("exe_mem_read", 32'(exe_mem_read), 32'(e.mr));
    chk("exe_mem_write", 32'(exe_mem_write), 32'(e.mw));
    chk("exe_jal", 32'(exe_jal), 32'(e.jal));
    chk("exe_jalr", 32'(exe_jalr), 32'(e.jalr));
    chk("exe_br_ctrl", 32'(exe_br_ctrl), 32'(e.br));
    if (e.v) begin
      chk("exe_pc", exe_pc, e.pc);
      chk("exe_rd", 32'(exe_rd), 32'(e.rd));
      chk("exe_rs1", 32'(exe_rs1), 32'(e.rs1));
      chk("exe_rs2", 32'(exe_rs2), 32'(e.rs2));
      chk("exe_illegal", 32'(exe_illegal), 32'(e.ill));
      if (!e.ill) begin
        chk("exe_alu_ctrl", 32'(exe_alu_ctrl), 32'(e.alu));
        chk("exe_imm", exe_imm, e.imm);
        chk("exe_alu_src_imm", 32'(exe_alu_src_imm), 32'(e.src));
      end
    end
  endtask

  // Called just after a falling edge with inputs driven; ends at the next falling edge.
  task automatic step(output bit stall);
    bit u1, u2;
    m_t d;
    #1;
    d = mdec(id_instr, u1, u2);
    stall = m.v && m.mr && m.rd != 0 && id_valid &&
            ((m.rd == id_instr[19:15] && u1) || (m.rd == id_instr[24:20] && u2));
    chk("load_use_stall", 32'(load_use_stall), 32'(stall));
    @(posedge clk);
    if (!hold) begin
      if (flush || stall || !id_valid) begin
        m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.jal = 0; m.jalr = 0; m.br = 0; m.ill = 0;
      end else begin
        m = d; m.pc = id_pc;
      end
    end
    #1;
    cmp_state(m);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    logic [31:0] ins = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 9 || ins[0]) ins[6:0] = ops[k];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    if (ins[6:0] == 7'h13 && $urandom_range(0, 3) != 0) ins[31:25] = ins[30] ? 7'h20 : 7'h00;
    return ins;
  endfunction

  vec_t vt [8];
  bit   st;

  initial begin
    vt[0] = '{32'h40B50533, 4'd1, 3'd0, 32'h00000000, 1'b0, 5'd10, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h40335293, 4'd7, 3'd0, 32'h00000003, 1'b1, 5'd5,  5'd6,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{32'hFE20DCE3, 4'd1, 3'd4, 32'hFFFFFFF8, 1'b0, 5'd25, 5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h123452B7, 4'd0, 3'd0, 32'h12345000, 1'b1, 5'd5,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h0000007F, 4'd0, 3'd0, 32'h00000000, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{32'h00512423, 4'd0, 3'd0, 32'h00000008, 1'b1, 5'd8,  5'd2,  5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{32'h010000EF, 4'd0, 3'd0, 32'h00000010, 1'b1, 5'd1,  5'd0,  5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{32'h00032283, 4'd0, 3'd0, 32'h00000000, 1'b1, 5'd5,  5'd6,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; id_valid = 1'b1; id_instr = 32'h40B50533; id_pc = 32'h40;
    hold = 1'b0; flush = 1'b0;
    m = '{default: 0};
    @(negedge clk);
    chk("reset exe_valid", 32'(exe_valid), 32'd0);
    chk("reset exe_alu_ctrl", 32'(exe_alu_ctrl), 32'd0);
    chk("reset exe_pc", exe_pc, 32'd0);
    chk("reset exe_imm", exe_imm, 32'd0);
    chk("reset load_use_stall", 32'(load_use_stall), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      id_instr = vt[i].ins; id_valid = 1'b1; id_pc = 32'h1000 + 32'(i * 4);
      step(st);
      chk("tbl exe_valid", 32'(exe_valid), 32'd1);
      chk("tbl exe_pc", exe_pc, 32'h1000 + 32'(i * 4));
      chk("tbl exe_rd", 32'(exe_rd), 32'(vt[i].rd));
      chk("tbl exe_rs1", 32'(exe_rs1), 32'(vt[i].rs1));
      chk("tbl exe_rs2", 32'(exe_rs2), 32'(vt[i].rs2));
      chk("tbl exe_br_ctrl", 32'(exe_br_ctrl), 32'(vt[i].br));
      chk("tbl exe_reg_write", 32'(exe_reg_write), 32'(vt[i].rw));
      chk("tbl exe_mem_read", 32'(exe_mem_read), 32'(vt[i].mr));
      chk("tbl exe_mem_write", 32'(exe_mem_write), 32'(vt[i].mw));
      chk("tbl exe_jal", 32'(exe_jal), 32'(vt[i].jal));
      chk("tbl exe_illegal", 32'(exe_illegal), 32'(vt[i].ill));
      if (!vt[i].ill) begin
        chk("tbl exe_alu_ctrl", 32'(exe_alu_ctrl), 32'(vt[i].alu));
        chk("tbl exe_imm", exe_imm, vt[i].imm);
        chk("tbl exe_alu_src_imm", 32'(exe_alu_src_imm), 32'(vt[i].src));
      end
    end

    // lw x5 is in EXE now; add x7,x5,x1 must stall exactly one cycle.
    id_instr = 32'h001283B3; id_pc = 32'h2000;
    #1 chk("lu stall asserted", 32'(load_use_stall), 32'd1);
    step(st);
    chk("lu bubble exe_valid", 32'(exe_valid), 32'd0);
    chk("lu stall released", 32'(load_use_stall), 32'd0);
    step(st);
    chk("lu add exe_valid", 32'(exe_valid), 32'd1);
    chk("lu add exe_rd", 32'(exe_rd), 32'd7);
    chk("lu add exe_alu_ctrl", 32'(exe_alu_ctrl), 32'd0);

    id_instr = 32'h40B50533; id_pc = 32'h3000;
    step(st);
    id_instr = 32'h40335293; hold = 1'b1; flush = 1'b1;
    step(st);
    chk("hold+flush exe_valid", 32'(exe_valid), 32'd1);
    chk("hold+flush exe_alu_ctrl", 32'(exe_alu_ctrl), 32'd1);
    chk("hold+flush exe_pc", exe_pc, 32'h3000);
    hold = 1'b0;
    step(st);
    chk("flush exe_valid", 32'(exe_valid), 32'd0);
    flush = 1'b0;

    id_instr = 32'h40B50533; id_pc = 32'h4000;
    step(st);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst exe_valid", 32'(exe_valid), 32'd0);
    chk("async rst exe_alu_ctrl", 32'(exe_alu_ctrl), 32'd0);
    chk("async rst exe_rd", 32'(exe_rd), 32'd0);
    chk("async rst exe_reg_write", 32'(exe_reg_write), 32'd0);
    m = '{default: 0};
    @(negedge clk);
    chk("rst held exe_valid", 32'(exe_valid), 32'd0);
    rst_n = 1'b1;
    step(st);
    chk("post rst load", 32'(exe_valid), 32'd1);

    st = 0;
    for (int c = 0; c < 400; c++) begin
      hold     = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      if (!(st || hold)) begin
        id_instr = rand_instr();
        id_pc    = $urandom;
        id_valid = ($urandom_range(0, 9) != 0);
      end
      step(st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
